agc_cdu_counter: RTL and testbench
==================================

// Module: agc_cdu_counter
// PURPOSE
//   AGC-side end of the CDU angle/error interface. Accumulates CDU +/- angle increment pulses
//   into a 15-bit two's-complement CDU counter. Drives the CDU error-counter enable and
//   rate-limited +/- error-drive pulses. Generates the stretched AGCZ zero discrete.
//   One instance per gimbal axis; sits between the CDU model and the AGC register model.
// PARAMETERS
//   CNT_W     15   CDU counter width (two's complement, modulo 2^CNT_W)
//   ERR_W     9    signed width of error-drive request (range -256..255)
//   RATE_DIV  320  clocks per error-drive pulse period (>= PULSE_W+1)
//   PULSE_W   2    clocks each error-drive pulse is held high (>= 1)
//   Z_W       4    clocks AGCZ is held high per zero request (>= 1)
// PORTS
//   CLOCKH    in   1      system clock, all state on rising edge
//   rst_n     in   1      asynchronous active-low reset
//   PCDU      in   1      CDU plus-increment pulse (level, asynchronous)
//   MCDU      in   1      CDU minus-increment pulse (level, asynchronous)
//   CNT_LD    in   1      software load strobe, one clock
//   CNT_LDVAL in   CNT_W  value loaded on CNT_LD
//   CDUCNT    out  CNT_W  accumulated angle count
//   CNT_OVF   out  1      one-clock pulse on counter wrap, either direction
//   ZERO_REQ  in   1      software zero strobe, one clock
//   AGCZ      out  1      zero discrete to CDU
//   ERR_EN    in   1      software error-counter enable
//   AGCEEC    out  1      registered copy of ERR_EN, to CDU
//   ERR_WR    in   1      error-drive request strobe, one clock
//   ERR_VAL   in   ERR_W  signed pulse count; sign selects ERRM (neg) or ERRP (pos)
//   ERRP      out  1      plus error-drive pulse to CDU
//   ERRM      out  1      minus error-drive pulse to CDU
//   ERR_BUSY  out  1      error-drive burst in progress
//   ERR_REJ   out  1      one-clock pulse: ERR_WR refused
// BEHAVIOUR
//   Reset: every output 0; CDUCNT=0; FSM IDLE; synchronisers cleared; asynchronous.
//   Increment path:
//   - PCDU/MCDU each pass a 2-FF synchroniser, then rising-edge detect.
//   - CDUCNT updates on the 3rd CLOCKH edge after the input rises.
//   - P and M edges detected in the same clock cancel: no change, no CNT_OVF.
//   - Arithmetic modulo 2^CNT_W: 0x7FFF+1 -> 0x0000 and 0x0000-1 -> 0x7FFF,
//     each raising CNT_OVF for one clock.
//   - Priority per clock: ZERO_REQ > CNT_LD > increment; the losing increment is discarded.
//   - A load never raises CNT_OVF.
//   Zero:
//   - ZERO_REQ clears CDUCNT on the same edge and sets AGCZ high for Z_W clocks.
//   - Increments detected while AGCZ=1 are discarded.
//   - ZERO_REQ while AGCZ=1 restarts the Z_W count.
//   Error drive: AGCEEC = ERR_EN delayed one clock. FSM states IDLE, PULSE, GAP.
//   - IDLE: ERR_WR with AGCEEC=1 and ERR_VAL!=0 latches REM=|ERR_VAL| (ERR_W bits,
//     unsigned) and DIR=sign, then goes to PULSE.
//   - IDLE: ERR_WR with ERR_VAL=0 is accepted and stays IDLE.
//   - IDLE: ERR_WR with AGCEEC=0 gives ERR_REJ.
//   - PULSE: ERRP (DIR=0) or ERRM (DIR=1) high for PULSE_W clocks; first pulse starts the clock
//     after ERR_WR; REM decrements at pulse end; then GAP.
//   - GAP: outputs low for RATE_DIV-PULSE_W clocks; then PULSE if REM!=0, else IDLE.
//   - ERR_BUSY=1 in PULSE and GAP.
//   - ERR_WR while ERR_BUSY=1: ignored, ERR_REJ pulses one clock.
//   - AGCEEC falling in PULSE or GAP: abort, REM cleared, ERRP/ERRM low on the next clock,
//     IDLE; no ERR_REJ.
//   - ERRP and ERRM are never high together.
//   - Increment path and error drive are independent and run concurrently.
//   - Reset mid-burst or mid-zero: immediate return to reset state; no partial pulse resumes.
// TESTING
//   5 PCDU + 3 MCDU pulses, well spaced -> CDUCNT=0x0002, CNT_OVF never set.
//   CNT_LD 0x7FFF then one PCDU -> CDUCNT=0x0000 with 1-clock CNT_OVF; one MCDU -> 0x7FFF, OVF again.
//   PCDU and MCDU rise on the same edge -> CDUCNT unchanged; ZERO_REQ beside a PCDU edge -> 0, AGCZ 4 clk.
//   RATE_DIV=8, PULSE_W=2, ERR_EN=1, ERR_WR ERR_VAL=-3 -> 3 ERRM pulses 2 clk wide every 8 clk; ERRP=0; BUSY drops.
//   ERR_VAL=+10, ERR_EN low after 2nd ERRP -> ERRP low next clk, BUSY=0; ERR_WR mid-burst -> ERR_REJ 1 clk.
//   rst_n low mid-burst with CDUCNT=0x1234 -> all outputs 0 asynchronously; after release, ERR_WR +1 -> one ERRP.

Source files
------------

// File: rtl/agc_cdu_counter.sv
// AGC-side CDU interface for one gimbal axis: synchronised +/- angle increments into a
// wrapping counter, a stretched zero discrete, and a rate-limited error-drive pulse burst.
module agc_cdu_counter #(
  parameter int CNT_W    = 15,
  parameter int ERR_W    = 9,
  parameter int RATE_DIV = 320,
  parameter int PULSE_W  = 2,
  parameter int Z_W      = 4
) (
  input  logic             CLOCKH,
  input  logic             rst_n,
  input  logic             PCDU,
  input  logic             MCDU,
  input  logic             CNT_LD,
  input  logic [CNT_W-1:0] CNT_LDVAL,
  output logic [CNT_W-1:0] CDUCNT,
  output logic             CNT_OVF,
  input  logic             ZERO_REQ,
  output logic             AGCZ,
  input  logic             ERR_EN,
  output logic             AGCEEC,
  input  logic             ERR_WR,
  input  logic [ERR_W-1:0] ERR_VAL,
  output logic             ERRP,
  output logic             ERRM,
  output logic             ERR_BUSY,
  output logic             ERR_REJ
);

  localparam int TMR_W = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
  localparam int ZC_W  = $clog2(Z_W + 1);
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_W - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(RATE_DIV - PULSE_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} state_t;

  logic [1:0]       p_sync_q, m_sync_q;
  logic             p_prev_q, m_prev_q;
  logic             p_rise, m_rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ZC_W-1:0]  z_q, z_d;
  logic             agceec_q;
  state_t           state_q, state_d;
  logic [ERR_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             rej_q, rej_d;
  logic [ERR_W-1:0] err_mag;

  assign p_rise = p_sync_q[1] & ~p_prev_q;
  assign m_rise = m_sync_q[1] & ~m_prev_q;

  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      p_sync_q <= '0;
      m_sync_q <= '0;
      p_prev_q <= 1'b0;
      m_prev_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      z_q      <= '0;
      agceec_q <= 1'b0;
    end else begin
      p_sync_q <= {p_sync_q[0], PCDU};
      m_sync_q <= {m_sync_q[0], MCDU};
      p_prev_q <= p_sync_q[1];
      m_prev_q <= m_sync_q[1];
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      z_q      <= z_d;
      agceec_q <= ERR_EN;
    end
  end

  // Simultaneous P and M edges cancel; increments seen during AGCZ are dropped.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (ZERO_REQ) begin
      cnt_d = '0;
    end else if (CNT_LD) begin
      cnt_d = CNT_LDVAL;
    end else if ((z_q == '0) && (p_rise ^ m_rise)) begin
      if (p_rise) begin
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = &cnt_q;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        ovf_d = ~|cnt_q;
      end
    end
  end

  always_comb begin
    z_d = z_q;
    if (ZERO_REQ)
      z_d = ZC_W'(Z_W);
    else if (z_q != '0)
      z_d = z_q - ZC_W'(1);
  end

  assign CDUCNT = cnt_q;
  assign CNT_OVF = ovf_q;
  assign AGCZ = (z_q != '0);
  assign AGCEEC = agceec_q;

  // Magnitude needs all ERR_W bits unsigned so the most negative request still fits.
  assign err_mag = ERR_VAL[ERR_W-1] ? (~ERR_VAL + ERR_W'(1)) : ERR_VAL;

  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      tmr_q   <= '0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      tmr_q   <= tmr_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    tmr_d   = tmr_q;
    rej_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ERR_WR) begin
          if (!agceec_q) begin
            rej_d = 1'b1;
          end else if (ERR_VAL != '0) begin
            rem_d   = err_mag;
            dir_d   = ERR_VAL[ERR_W-1];
            tmr_d   = '0;
            state_d = PULSE;
          end
        end
      end
      PULSE, GAP: begin
        rej_d = ERR_WR;
        if (!agceec_q) begin
          state_d = IDLE;
          rem_d   = '0;
          tmr_d   = '0;
        end else if (state_q == PULSE) begin
          if (tmr_q == PULSE_LAST) begin
            tmr_d   = '0;
            rem_d   = rem_q - ERR_W'(1);
            state_d = GAP;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end else begin
          if (tmr_q == GAP_LAST) begin
            tmr_d   = '0;
            state_d = (rem_q != '0) ? PULSE : IDLE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ERRP     = (state_q == PULSE) && !dir_q;
    ERRM     = (state_q == PULSE) && dir_q;
    ERR_BUSY = (state_q != IDLE);
    ERR_REJ  = rej_q;
  end

endmodule

// File: tb/tb_agc_cdu_counter.sv
// Scoreboard bench for agc_cdu_counter: stimulus pushes expected events, a negedge
// monitor pops and compares them as the DUT produces counter changes and pulses.
module tb_agc_cdu_counter;

  localparam int CNT_W = 15;
  localparam int ERR_W = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pcdu = 1'b0, mcdu = 1'b0, cnt_ld = 1'b0, zero_req = 1'b0;
  logic             err_en = 1'b0, err_wr = 1'b0;
  logic [CNT_W-1:0] cnt_ldval = '0;
  logic [ERR_W-1:0] err_val = '0;
  logic [CNT_W-1:0] cducnt;
  logic             cnt_ovf, agcz, agceec, errp, errm, err_busy, err_rej;

  agc_cdu_counter #(.CNT_W(CNT_W), .ERR_W(ERR_W), .RATE_DIV(8), .PULSE_W(2), .Z_W(4)) dut (
    .CLOCKH(clk), .rst_n(rst_n), .PCDU(pcdu), .MCDU(mcdu), .CNT_LD(cnt_ld),
    .CNT_LDVAL(cnt_ldval), .CDUCNT(cducnt), .CNT_OVF(cnt_ovf), .ZERO_REQ(zero_req),
    .AGCZ(agcz), .ERR_EN(err_en), .AGCEEC(agceec), .ERR_WR(err_wr), .ERR_VAL(err_val),
    .ERRP(errp), .ERRM(errm), .ERR_BUSY(err_busy), .ERR_REJ(err_rej)
  );

  always #5 clk = ~clk;

  typedef struct {int dir; int w; int per;} pulse_t;

  int     n_checks = 0;
  int     n_fail = 0;
  int     exp_cnt[$];
  int     exp_ovf[$];
  int     exp_z[$];
  int     exp_rej[$];
  int     exp_busy[$];
  pulse_t exp_pl[$];
  logic   mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  task automatic unexpected(input string nm, input int act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event, value %0d (0x%0h), nothing queued", nm, act, act);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic inc_pulse(input bit plus);
    if (plus) pcdu = 1'b1; else mcdu = 1'b1;
    tick(4);
    pcdu = 1'b0;
    mcdu = 1'b0;
    tick(4);
  endtask

  task automatic load(input int v);
    exp_cnt.push_back(v);
    cnt_ldval = CNT_W'(v);
    cnt_ld = 1'b1;
    tick(1);
    cnt_ld = 1'b0;
    tick(1);
  endtask

  task automatic err_write(input int v);
    err_val = ERR_W'(v);
    err_wr = 1'b1;
    tick(1);
    err_wr = 1'b0;
  endtask

  // Monitor
  int         cyc = 0;
  int         prev_cnt = 0;
  logic       prev_z = 1'b0, prev_pl = 1'b0, prev_busy = 1'b0;
  int         z_w = 0, pl_w = 0, pl_dir = 0, pl_per = 0, last_start = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (int'(cducnt) != prev_cnt) begin
        if (exp_cnt.size() == 0) unexpected("cducnt", int'(cducnt));
        else begin
          chk("cducnt", int'(cducnt), exp_cnt.pop_front());
          $display("txn cducnt -> 0x%04h", cducnt);
        end
      end
      if (cnt_ovf) begin
        if (exp_ovf.size() == 0) unexpected("cnt_ovf", int'(cducnt));
        else begin
          chk("cnt_ovf_count", int'(cducnt), exp_ovf.pop_front());
          $display("txn cnt_ovf at 0x%04h", cducnt);
        end
      end
      if (agcz) z_w++;
      if (!agcz && prev_z) begin
        if (exp_z.size() == 0) unexpected("agcz_width", z_w);
        else begin
          chk("agcz_width", z_w, exp_z.pop_front());
          $display("txn agcz width %0d", z_w);
        end
        z_w = 0;
      end
      if (errp && errm) unexpected("errp_errm_overlap", cyc);
      if ((errp || errm) && !prev_pl) begin
        pl_dir = errm ? 1 : 0;
        pl_w = 0;
        pl_per = cyc - last_start;
        last_start = cyc;
      end
      if (errp || errm) pl_w++;
      if (!(errp || errm) && prev_pl) begin
        if (exp_pl.size() == 0) unexpected("err_pulse", pl_w);
        else begin
          pulse_t e;
          e = exp_pl.pop_front();
          chk("pulse_dir", pl_dir, e.dir);
          chk("pulse_width", pl_w, e.w);
          if (e.per != 0) chk("pulse_period", pl_per, e.per);
          $display("txn err pulse dir=%0d width=%0d period=%0d", pl_dir, pl_w, pl_per);
        end
      end
      if (err_rej) begin
        if (exp_rej.size() == 0) unexpected("err_rej", cyc);
        else begin
          chk("err_rej", 1, exp_rej.pop_front());
          $display("txn err_rej");
        end
      end
      if (!err_busy && prev_busy) begin
        if (exp_busy.size() == 0) unexpected("busy_fall", cyc);
        else begin
          chk("busy_fall", 1, exp_busy.pop_front());
          $display("txn err_busy dropped");
        end
      end
    end
    prev_cnt  = int'(cducnt);
    prev_z    = agcz;
    prev_pl   = errp | errm;
    prev_busy = err_busy;
  end

  initial begin
    #2;
    chk("rst_cducnt", int'(cducnt), 0);
    chk("rst_outputs", int'({cnt_ovf, agcz, agceec, errp, errm, err_busy, err_rej}), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    mon_en = 1'b1;

    // 5 plus, 3 minus -> 2
    for (int i = 1; i <= 5; i++) begin
      exp_cnt.push_back(i);
      inc_pulse(1'b1);
    end
    for (int i = 4; i >= 2; i--) begin
      exp_cnt.push_back(i);
      inc_pulse(1'b0);
    end

    // wrap both directions
    load(32'h7FFF);
    exp_cnt.push_back(0);
    exp_ovf.push_back(0);
    inc_pulse(1'b1);
    exp_cnt.push_back(32'h7FFF);
    exp_ovf.push_back(32'h7FFF);
    inc_pulse(1'b0);

    // coincident edges cancel
    pcdu = 1'b1;
    mcdu = 1'b1;
    tick(4);
    pcdu = 1'b0;
    mcdu = 1'b0;
    tick(4);

    // zero beats a coincident PCDU edge; an MCDU edge during AGCZ is dropped
    pcdu = 1'b1;
    tick(2);
    exp_cnt.push_back(0);
    exp_z.push_back(4);
    zero_req = 1'b1;
    tick(1);
    zero_req = 1'b0;
    mcdu = 1'b1;
    tick(6);
    pcdu = 1'b0;
    mcdu = 1'b0;
    tick(4);

    // error drive -3
    err_en = 1'b1;
    tick(2);
    exp_pl.push_back('{1, 2, 0});
    exp_pl.push_back('{1, 2, 8});
    exp_pl.push_back('{1, 2, 8});
    exp_busy.push_back(1);
    err_write(-3);
    tick(30);
    err_write(0);
    tick(3);

    // +10, rejected write mid-burst, abort after second pulse
    exp_pl.push_back('{0, 2, 0});
    exp_pl.push_back('{0, 2, 8});
    exp_rej.push_back(1);
    exp_busy.push_back(1);
    err_write(10);
    tick(2);
    err_write(5);
    tick(8);
    err_en = 1'b0;
    tick(6);
    exp_rej.push_back(1);
    err_write(5);
    tick(3);

    // reset mid-burst
    err_en = 1'b1;
    tick(2);
    load(32'h1234);
    exp_pl.push_back('{0, 2, 0});
    exp_busy.push_back(1);
    exp_cnt.push_back(0);
    err_write(10);
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cducnt", int'(cducnt), 0);
    chk("midrst_outputs", int'({cnt_ovf, agcz, agceec, errp, errm, err_busy, err_rej}), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    exp_pl.push_back('{0, 2, 0});
    exp_busy.push_back(1);
    err_write(1);
    tick(14);

    chk("left_cnt", exp_cnt.size(), 0);
    chk("left_ovf", exp_ovf.size(), 0);
    chk("left_z", exp_z.size(), 0);
    chk("left_pulse", exp_pl.size(), 0);
    chk("left_rej", exp_rej.size(), 0);
    chk("left_busy", exp_busy.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
